// File: rtl/fetch_unit_if.sv
// Fetch unit boundary: pipeline-control redirect inputs, instruction memory
// request/response channel and the decode-side valid/ready stream.
interface fetch_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic [1:0]      pc_next_address_sel;
  logic [XLEN-1:0] jal_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] branch_target;
  logic            flush;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            fetch_misalign;

  // Fetch unit side
  modport master (
    input  pc_next_address_sel, jal_target, jalr_target, branch_target, flush,
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output id_valid,
    input  id_ready,
    output id_instr, id_pc, fetch_misalign
  );

  // Surrounding pipeline / memory side
  modport slave (
    output pc_next_address_sel, jal_target, jalr_target, branch_target, flush,
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  id_valid,
    output id_ready,
    input  id_instr, id_pc, fetch_misalign
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the fetch PC, issues credit-limited
// requests to a variable-latency instruction memory, tags each request with
// an epoch bit so responses from before a redirect/flush are dropped, and
// buffers returned instructions in a small queue feeding decode.
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CRD_W = CNT_W + 1;
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic {RUN, REDIRECT} state_t;

  state_t          state;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fetch_pc;
  logic            epoch;
  logic            misalign;

  // In-flight request tags: epoch at issue time plus the request PC
  logic [BUF_DEPTH-1:0] tag_epoch;
  logic [XLEN-1:0]      tag_pc [BUF_DEPTH];
  logic [PTR_W-1:0]     tag_wr;
  logic [PTR_W-1:0]     tag_rd;
  logic [CNT_W-1:0]     outstanding;

  // Instruction queue towards decode
  logic [31:0]      q_instr [BUF_DEPTH];
  logic [XLEN-1:0]  q_pc    [BUF_DEPTH];
  logic [PTR_W-1:0] q_wr;
  logic [PTR_W-1:0] q_rd;
  logic [CNT_W-1:0] q_count;

  logic             kill;
  logic [CRD_W-1:0] credit_used;
  logic             issue;
  logic             grant;
  logic             rsp_fire;
  logic             rsp_keep;
  logic             deliver;
  logic             pop;

  // Redirect detection and target selection; REDIRECT lasts exactly the sel != 0 cycle
  always_comb begin
    target = bus.jal_target;
    state  = RUN;
    case (bus.pc_next_address_sel)
      2'd1: begin
        target = bus.jal_target;
        state  = REDIRECT;
      end
      2'd2: begin
        target = bus.jalr_target;
        state  = REDIRECT;
      end
      2'd3: begin
        target = bus.branch_target;
        state  = REDIRECT;
      end
      default: ;
    endcase
  end

  assign kill        = (state == REDIRECT) || bus.flush;
  assign credit_used = CRD_W'(outstanding) + CRD_W'(q_count);
  // rst_n term keeps imem_req low while reset is held
  assign issue       = rst_n && (state == RUN) && (credit_used < CRD_W'(BUF_DEPTH));
  assign grant       = issue && bus.imem_gnt;
  assign rsp_fire    = bus.imem_rvalid && (outstanding != '0);
  assign rsp_keep    = rsp_fire && !kill && (tag_epoch[tag_rd] == epoch);
  assign deliver     = (q_count != '0) && !kill;
  assign pop         = deliver && bus.id_ready;

  assign bus.imem_req       = issue;
  assign bus.imem_addr      = fetch_pc;
  assign bus.id_valid       = deliver;
  assign bus.id_instr       = (q_count == '0) ? NOP : q_instr[q_rd];
  assign bus.id_pc          = q_pc[q_rd];
  assign bus.fetch_misalign = misalign;

  // Fetch PC, epoch and one-cycle misaligned-target pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      epoch    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      misalign <= (state == REDIRECT) && (target[1:0] != 2'b00);
      if (kill) begin
        epoch <= ~epoch;
      end
      if (state == REDIRECT) begin
        fetch_pc <= {target[XLEN-1:2], 2'b00};
      end else if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  // In-flight tag FIFO; a grant during a flush already carries the post-flush epoch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_epoch   <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        tag_pc[i] <= '0;
      end
    end else begin
      if (grant) begin
        tag_epoch[tag_wr] <= epoch ^ bus.flush;
        tag_pc[tag_wr]    <= fetch_pc;
        tag_wr            <= tag_wr + PTR_W'(1);
      end
      if (rsp_fire) begin
        tag_rd <= tag_rd + PTR_W'(1);
      end
      outstanding <= outstanding + CNT_W'(grant) - CNT_W'(rsp_fire);
    end
  end

  // Instruction queue; cleared on redirect or flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        q_instr[i] <= NOP;
        q_pc[i]    <= RESET_PC;
      end
    end else if (kill) begin
      q_wr    <= '0;
      q_rd    <= '0;
      q_count <= '0;
    end else begin
      if (rsp_keep) begin
        q_instr[q_wr] <= bus.imem_rdata;
        q_pc[q_wr]    <= tag_pc[tag_rd];
        q_wr          <= q_wr + PTR_W'(1);
      end
      if (pop) begin
        q_rd <= q_rd + PTR_W'(1);
      end
      q_count <= q_count + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table plus hand-written
// sequences for reset-with-outstanding-request and flush-during-grant.
// Memory model: grants are queued and answered in order one cycle later,
// unless the vector holds responses back; instr(addr) = {8'hA5, addr[23:0]}.
module tb_fetch_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(
    .XLEN      (XLEN),
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic        rst;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        fl;
    logic        gnt;
    logic        rdy;
    logic        hld;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_mis;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] pend[$];
  int          total;
  int          bad;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  function automatic vec_t mk(input int rst, input int sel, input int tgt, input int fl,
                              input int gnt, input int rdy, input int hld,
                              input int e_req, input int e_addr, input int e_valid,
                              input int e_pc, input int e_mis);
    vec_t v;
    v.rst     = rst[0];
    v.sel     = sel[1:0];
    v.tgt     = tgt;
    v.fl      = fl[0];
    v.gnt     = gnt[0];
    v.rdy     = rdy[0];
    v.hld     = hld[0];
    v.e_req   = e_req[0];
    v.e_addr  = e_addr;
    v.e_valid = e_valid[0];
    v.e_pc    = e_pc;
    v.e_mis   = e_mis[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive all inputs for the current cycle (called at the falling edge)
  task automatic drive(input logic rst, input logic [1:0] sel, input logic [31:0] tgt,
                       input logic fl, input logic gnt, input logic rdy, input logic hld);
    rst_n                   = rst;
    bus.pc_next_address_sel = sel;
    bus.jal_target          = (sel == 2'd1) ? tgt : JUNK;
    bus.jalr_target         = (sel == 2'd2) ? tgt : JUNK;
    bus.branch_target       = (sel == 2'd3) ? tgt : JUNK;
    bus.flush               = fl;
    bus.imem_gnt            = gnt;
    bus.id_ready            = rdy;
    bus.imem_rvalid         = (pend.size() != 0) && !hld;
    bus.imem_rdata          = (pend.size() != 0) ? instr_of(pend[0]) : 32'hDEAD_0000;
    #1;
  endtask

  // Advance one clock and update the memory model from what crossed the edge
  task automatic step();
    logic        fire;
    logic        rv;
    logic [31:0] addr;
    fire = bus.imem_req && bus.imem_gnt;
    addr = bus.imem_addr;
    rv   = bus.imem_rvalid;
    @(posedge clk);
    if (rv && pend.size() != 0) pend.delete(0);
    if (fire) pend.push_back(addr);
    @(negedge clk);
  endtask

  // Bounded wait for id_valid; checks the cycle it appears and the delivered entry
  task automatic wait_valid(input string name, input int exp_cyc, input logic [31:0] exp_pc);
    int found;
    found = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
      if (bus.id_valid) begin
        found = k;
        break;
      end
    end
    if (found < 0) begin
      total++;
      bad++;
      $display("FAIL %s: id_valid not seen within 8 cycles", name);
    end else begin
      check({name, " cycle"}, 32'(found), 32'(exp_cyc));
      check({name, " pc"}, bus.id_pc, exp_pc);
      check({name, " instr"}, bus.id_instr, instr_of(exp_pc));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    //          rst sel tgt    fl gnt rdy hld   req addr    vld pc     mis
    tbl.push_back(mk(0, 0, 'h0,   0, 0,  0,  0,    0, 'h0,    0, 'h0,   0)); // in reset
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h0,    0, 'h0,   0)); // first request
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h4,    0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h0,   0)); // grant+2
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h8,    1, 'h4,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'hC,    0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h8,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h10,   1, 'hC,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h14,   0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  0,  0,    0, 'h0,    1, 'h10,  0)); // decode stalls
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  0,  0,    0, 'h0,    1, 'h10,  0)); // queue full
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  0,  0,    0, 'h0,    1, 'h10,  0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h10,  0)); // drain
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h18,   1, 'h14,  0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  1,    1, 'h1C,   0, 'h0,   0)); // 2 outstanding
    tbl.push_back(mk(1, 3, 'h100, 0, 1,  1,  0,    0, 'h0,    0, 'h0,   0)); // branch
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h100,  0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h104,  0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h100, 0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h108,  1, 'h104, 0));
    tbl.push_back(mk(1, 2, 'h203, 0, 1,  1,  0,    0, 'h0,    0, 'h0,   0)); // jalr, misaligned
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h200,  0, 'h0,   1));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h204,  0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h200, 0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h208,  1, 'h204, 0));
    tbl.push_back(mk(1, 1, 'h38,  0, 1,  1,  0,    0, 'h0,    0, 'h0,   0)); // jal 0x38
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  0,  0,    1, 'h38,   0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  0,  0,    1, 'h3C,   0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   1, 1,  0,  0,    0, 'h0,    0, 'h0,   0)); // flush
    tbl.push_back(mk(1, 0, 'h0,   0, 0,  1,  0,    1, 'h40,   0, 'h0,   0)); // no grant
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h40,   0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    1, 'h44,   0, 'h0,   0));
    tbl.push_back(mk(1, 0, 'h0,   0, 1,  1,  0,    0, 'h0,    1, 'h40,  0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.sel, v.tgt, v.fl, v.gnt, v.rdy, v.hld);
      check($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(v.e_req));
      if (v.e_req) check($sformatf("v%0d imem_addr", i), bus.imem_addr, v.e_addr);
      check($sformatf("v%0d id_valid", i), 32'(bus.id_valid), 32'(v.e_valid));
      if (v.e_valid) begin
        check($sformatf("v%0d id_pc", i), bus.id_pc, v.e_pc);
        check($sformatf("v%0d id_instr", i), bus.id_instr, instr_of(v.e_pc));
      end
      check($sformatf("v%0d fetch_misalign", i), 32'(bus.fetch_misalign), 32'(v.e_mis));
      if (!v.rst) begin
        check($sformatf("v%0d reset id_instr", i), bus.id_instr, NOP);
        check($sformatf("v%0d reset id_pc", i), bus.id_pc, 32'h0);
      end
      step();
    end

    // Reset while a request is outstanding; its late response must be ignored
    drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pre-reset imem_req", 32'(bus.imem_req), 32'h1);
    check("pre-reset imem_addr", bus.imem_addr, 32'h48);
    step();
    drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("reset imem_req", 32'(bus.imem_req), 32'h0);
    check("reset id_valid", 32'(bus.id_valid), 32'h0);
    check("reset id_instr", bus.id_instr, NOP);
    check("reset id_pc", bus.id_pc, 32'h0);
    check("reset fetch_misalign", 32'(bus.fetch_misalign), 32'h0);
    step();
    drive(1'b1, 2'd0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("post-reset stale rvalid present", 32'(bus.imem_rvalid), 32'h1);
    check("post-reset imem_req", 32'(bus.imem_req), 32'h1);
    check("post-reset imem_addr", bus.imem_addr, 32'h0);
    wait_valid("post-reset first delivery", 2, 32'h0);

    // Flush in the same cycle as a grant: that request belongs to the new epoch
    step();
    drive(1'b1, 2'd0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush+grant id_valid", 32'(bus.id_valid), 32'h0);
    check("flush+grant imem_req", 32'(bus.imem_req), 32'h1);
    check("flush+grant imem_addr", bus.imem_addr, 32'h8);
    wait_valid("flush+grant delivery", 2, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end. It consumes the next-PC selection and flush signals that pipeline control produces, and it generates the instruction stream that pipeline control decodes. It owns the fetch PC and issues requests to a variable-latency instruction memory. It buffers returned instructions in a 2-entry queue feeding the IF/ID register with a valid/ready handshake, and it discards in-flight fetches when the PC is redirected.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h00000000, fetch PC after reset
BUF_DEPTH, 2, instruction queue depth; also the maximum number of outstanding requests plus queued entries (fixed at 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
pc_next_address_sel  input  2  0 = sequential (pc+4), 1 = jal, 2 = jalr, 3 = taken branch
jal_target  input  XLEN  target used when sel=1
jalr_target  input  XLEN  target used when sel=2
branch_target  input  XLEN  target used when sel=3
flush  input  1  kill IF/ID contents (driven by should_stall_0_1); no PC change by itself
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, word aligned
imem_gnt  input  1  request accepted this cycle
imem_rvalid  input  1  response valid; responses return in order
imem_rdata  input  32  instruction word
id_valid  output  1  instruction available to decode
id_ready  input  1  decode accepts
id_instr  output  32  instruction
id_pc  output  XLEN  PC of id_instr
fetch_misalign  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]

Behaviour:
- Redirect: occurs when pc_next_address_sel != 0. The selected target, with bits [1:0] forced to 0, is loaded into fetch_pc at the next edge. fetch_misalign pulses in the cycle after a target with nonzero low bits.
- Redirect cycle actions: imem_req forced 0; id_valid forced 0; queue cleared at the edge; epoch bit toggled.
- flush without a redirect: clears the queue and toggles the epoch. fetch_pc does not change, so fetching continues at the current fetch_pc.
- Issue condition: imem_req = 1 when not redirecting and (outstanding + queue_count) < 2.
  - imem_addr = fetch_pc.
  - On imem_req && imem_gnt: fetch_pc += 4 (mod 2^XLEN, wraps silently), and the current epoch is pushed into a 2-entry in-flight tag FIFO.
- Response handling: on imem_rvalid, pop one tag.
  - Tag == current epoch: push {imem_rdata, pc} into the queue. The PC is tracked per request in the tag FIFO alongside the epoch.
  - Tag stale: discard silently.
  - imem_rvalid while outstanding == 0: ignored.
- Queue output: id_valid = (queue_count != 0) && no redirect/flush this cycle. id_instr/id_pc show the head entry; the head is popped on id_valid && id_ready.
- Latency: grant at cycle N, earliest imem_rvalid at N+1, id_valid at N+2. There is no combinational path from imem_rdata to id_instr.
- Simultaneous events:
  - Push and pop in the same cycle: both occur; count is unchanged.
  - Grant and response in the same cycle: both tag-FIFO operations occur.
  - Redirect and response in the same cycle: the response is treated as stale regardless of its tag.
  - Credit rule guarantees the queue never overflows. Queue empty: id_valid = 0 and id_instr = 32'h00000013 (NOP).
- Reset (asynchronous, any time):
  - fetch_pc = RESET_PC, epoch = 0.
  - outstanding = 0, queue_count = 0.
  - imem_req = 0, id_valid = 0, fetch_misalign = 0, id_instr = NOP, id_pc = RESET_PC.
  - Responses to pre-reset grants are ignored (outstanding == 0). Requests resume the first cycle after rst_n deasserts.
- States: RUN (issuing/receiving) and REDIRECT (single cycle, imem_req = 0). REDIRECT always returns to RUN, or re-enters REDIRECT if sel != 0 again.

Test Plan:
- Reset release, imem grants every cycle with 1-cycle rvalid, id_ready=1 -> imem_addr 0,4,8,...; first id_valid 2 cycles after first grant; id_pc 0,4,8 with matching instrs.
- id_ready=0 held -> exactly 2 requests granted, then imem_req=0 with 2 entries queued. Raise id_ready -> entries drain in order and requests resume.
- Branch redirect sel=3, target 0x100, with 2 requests outstanding -> both responses dropped; next imem_addr=0x100; first id_pc=0x100.
- jalr target 0x203 -> imem_addr 0x200; fetch_misalign pulses once.
- flush only, fetch_pc=0x40 with one queued entry at 0x38 -> queue empties; next delivered id_pc=0x40 (0x3C response discarded if in flight).
- rst_n asserted with a request outstanding; stale rvalid arrives after release -> ignored; first id_pc = RESET_PC.
